// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl_pkg: shared constants and types for the Wishbone GPIO controller.
//   - word offsets (adr_i[4:2]) of the register map
//   - maximum supported pin count
//   - bus handshake state type
package gpio_ctrl_pkg;

   localparam int unsigned GPIO_MAX_WIDTH = 32;

   localparam logic [2:0] GPIO_OUT        = 3'd0;
   localparam logic [2:0] GPIO_DIR        = 3'd1;
   localparam logic [2:0] GPIO_IN         = 3'd2;
   localparam logic [2:0] GPIO_RISE_EN    = 3'd3;
   localparam logic [2:0] GPIO_FALL_EN    = 3'd4;
   localparam logic [2:0] GPIO_IRQ_STATUS = 3'd5;
   localparam logic [2:0] GPIO_IRQ_MASK   = 3'd6;

   typedef enum logic {
      StIdle,
      StResp
   } bus_state_t;

endpackage

// File: rtl/gpio_ctrl_sync.sv
// sync_edge: multi-flop synchroniser for a vector of asynchronous inputs, plus one
// extra delayed copy of the synchronised value for edge detection.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   din          : asynchronous inputs
//   sync         : din after SYNC_STAGES flops
//   sync_d       : sync delayed by one more cycle
module sync_edge #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] sync,
   output logic [WIDTH-1:0] sync_d
);

   // Stage 0 samples the pad; stage SYNC_STAGES-1 is the settled value.
   logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
   logic [WIDTH-1:0]                  delay_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         chain_q <= '0;
         delay_q <= '0;
      end else begin
         chain_q <= {chain_q[SYNC_STAGES-2:0], din};
         delay_q <= chain_q[SYNC_STAGES-1];
      end
   end

   assign sync   = chain_q[SYNC_STAGES-1];
   assign sync_d = delay_q;

endmodule

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: Wishbone-slave GPIO controller with per-pin direction, synchronised
// inputs and edge-detect interrupts (W1C status, masked level irq).
// Ports:
//   clk_i, rst_i                : clock, asynchronous active-high reset
//   stb_i, cyc_i, we_i          : Wishbone strobe, cycle, write enable
//   adr_i, sel_i, dat_i         : byte address, byte selects, write data
//   dat_o, ack_o, err_o, rty_o  : read data and terminations (rty_o tied low)
//   pin_input                   : asynchronous pad inputs
//   pin_output, pin_oe          : output values and drive enables
//   irq_o                       : registered level interrupt
module gpio_ctrl
   import gpio_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE_ADDRESS = 32'h0,
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stb_i,
   input  logic             cyc_i,
   input  logic             we_i,
   input  logic [31:0]      adr_i,
   input  logic [3:0]       sel_i,
   input  logic [31:0]      dat_i,
   output logic [31:0]      dat_o,
   output logic             ack_o,
   output logic             err_o,
   output logic             rty_o,
   input  logic [WIDTH-1:0] pin_input,
   output logic [WIDTH-1:0] pin_output,
   output logic [WIDTH-1:0] pin_oe,
   output logic             irq_o
);

   bus_state_t state_q;

   logic [WIDTH-1:0] out_q, dir_q, rise_en_q, fall_en_q, status_q, mask_q;
   logic [WIDTH-1:0] sync, sync_d, rise, fall, clr, wdat;
   logic [GPIO_MAX_WIDTH-1:0] rdata;
   logic [2:0] offset;
   logic in_window, req, bad, wr;

   // Byte lane bits and write-data bits above WIDTH carry no information.
   logic unused_bits;
   assign unused_bits = ^{dat_i, adr_i[1:0]};

   sync_edge #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .din   (pin_input),
      .sync  (sync),
      .sync_d(sync_d)
   );

   assign offset    = adr_i[4:2];
   assign in_window = (adr_i[31:5] == BASE_ADDRESS[31:5]);
   assign req       = stb_i & cyc_i & in_window & (state_q == StIdle) & ~ack_o & ~err_o;
   assign bad       = (sel_i != 4'hF) | (offset == 3'd7) | (we_i & (offset == GPIO_IN));
   assign wr        = req & we_i & ~bad;
   assign wdat      = dat_i[WIDTH-1:0];

   assign rise = sync & ~sync_d & rise_en_q;
   assign fall = ~sync & sync_d & fall_en_q;
   assign clr  = (wr && offset == GPIO_IRQ_STATUS) ? wdat : '0;

   always_comb begin
      rdata = '0;
      case (offset)
         GPIO_OUT:        rdata[WIDTH-1:0] = out_q;
         GPIO_DIR:        rdata[WIDTH-1:0] = dir_q;
         GPIO_IN:         rdata[WIDTH-1:0] = sync;
         GPIO_RISE_EN:    rdata[WIDTH-1:0] = rise_en_q;
         GPIO_FALL_EN:    rdata[WIDTH-1:0] = fall_en_q;
         GPIO_IRQ_STATUS: rdata[WIDTH-1:0] = status_q;
         GPIO_IRQ_MASK:   rdata[WIDTH-1:0] = mask_q;
         default:         rdata = '0;
      endcase
   end

   // Register file; status set terms are OR'd after the clear so a
   // simultaneous event wins over a W1C.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         out_q     <= '0;
         dir_q     <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         status_q  <= '0;
         mask_q    <= '0;
      end else begin
         status_q <= (status_q & ~clr) | rise | fall;
         if (wr) begin
            case (offset)
               GPIO_OUT:      out_q     <= wdat;
               GPIO_DIR:      dir_q     <= wdat;
               GPIO_RISE_EN:  rise_en_q <= wdat;
               GPIO_FALL_EN:  fall_en_q <= wdat;
               GPIO_IRQ_MASK: mask_q    <= wdat;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         irq_o <= 1'b0;
      end else begin
         irq_o <= |(status_q & mask_q);
      end
   end

   // Bus handshake: one-cycle ack/err pulse, read data held only during RESP.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         ack_o   <= 1'b0;
         err_o   <= 1'b0;
         dat_o   <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req) begin
                  state_q <= StResp;
                  ack_o   <= ~bad;
                  err_o   <= bad;
                  dat_o   <= (we_i | bad) ? '0 : rdata;
               end
            end
            StResp: begin
               state_q <= StIdle;
               ack_o   <= 1'b0;
               err_o   <= 1'b0;
               dat_o   <= '0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign rty_o      = 1'b0;
   assign pin_output = out_q;
   assign pin_oe     = dir_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Scoreboard bench for gpio_ctrl: bus tasks push expected responses, a negedge
// monitor pops and compares whenever ack_o or err_o is presented.
module tb_gpio_ctrl;

   localparam logic [31:0] BASE  = 32'h0000_0100;
   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             stb = 1'b0, cyc = 1'b0, we = 1'b0;
   logic [31:0]      adr = '0;
   logic [3:0]       sel = '0;
   logic [31:0]      wdat = '0;
   logic [31:0]      dat_o;
   logic             ack_o, err_o, rty_o, irq_o;
   logic [WIDTH-1:0] pin_input = '0;
   logic [WIDTH-1:0] pin_output, pin_oe;

   typedef struct packed {
      logic        err;
      logic        chk;
      logic [31:0] dat;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    checks = 0;
   int    passed = 0;

   gpio_ctrl #(
      .BASE_ADDRESS(BASE),
      .WIDTH       (WIDTH),
      .SYNC_STAGES (2)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .stb_i     (stb),
      .cyc_i     (cyc),
      .we_i      (we),
      .adr_i     (adr),
      .sel_i     (sel),
      .dat_i     (wdat),
      .dat_o     (dat_o),
      .ack_o     (ack_o),
      .err_o     (err_o),
      .rty_o     (rty_o),
      .pin_input (pin_input),
      .pin_output(pin_output),
      .pin_oe    (pin_oe),
      .irq_o     (irq_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got 0x%08h, wanted 0x%08h", name, act, req);
   endtask

   // Monitor: compare every presented response against the scoreboard head.
   always @(negedge clk) begin
      if (!rst && (ack_o || err_o)) begin
         if (exp_q.size() == 0) begin
            check("unexpected response", {30'd0, ack_o, err_o}, 32'd0);
         end else begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check({n, " term{ack,err}"}, {30'd0, ack_o, err_o}, {30'd0, ~e.err, e.err});
            if (e.chk) check({n, " data"}, dat_o, e.dat);
         end
      end
   end

   // One single-word access; called at a negedge, returns one idle cycle later.
   task automatic bus(input logic w, input logic [4:0] off, input logic [3:0] s,
                      input logic [31:0] d, input logic e_err, input logic e_chk,
                      input logic [31:0] e_dat, input string name);
      exp_t e;
      e.err = e_err;
      e.chk = e_chk;
      e.dat = e_dat;
      exp_q.push_back(e);
      name_q.push_back(name);
      stb  = 1'b1;
      cyc  = 1'b1;
      we   = w;
      adr  = BASE + {27'd0, off};
      sel  = s;
      wdat = d;
      @(posedge clk);
      @(negedge clk);
      check({name, " latency"}, {31'd0, ack_o | err_o}, 32'd1);
      stb = 1'b0;
      cyc = 1'b0;
      we  = 1'b0;
      @(negedge clk);
   endtask

   task automatic rd(input logic [4:0] off, input logic [31:0] e_dat, input string name);
      bus(1'b0, off, 4'hF, 32'd0, 1'b0, 1'b1, e_dat, name);
   endtask

   task automatic wr(input logic [4:0] off, input logic [31:0] d, input string name);
      bus(1'b1, off, 4'hF, d, 1'b0, 1'b0, 32'd0, name);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, wanted finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset pin_output", {24'd0, pin_output}, 32'd0);
      check("reset pin_oe", {24'd0, pin_oe}, 32'd0);
      check("reset irq_o/ack/err", {29'd0, irq_o, ack_o, err_o}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 7; i++) rd(5'(i * 4), 32'd0, $sformatf("reset read 0x%02h", i * 4));
      bus(1'b0, 5'h1C, 4'hF, 32'd0, 1'b1, 1'b0, 32'd0, "read 0x1C");

      wr(5'h00, 32'hFFFF_FFA5, "write OUT");
      wr(5'h04, 32'h0000_000F, "write DIR");
      check("pin_output", {24'd0, pin_output}, 32'h0000_00A5);
      check("pin_oe", {24'd0, pin_oe}, 32'h0000_000F);
      rd(5'h00, 32'h0000_00A5, "readback OUT");
      rd(5'h04, 32'h0000_000F, "readback DIR");

      // Sampled one edge after the change: chain not yet settled.
      pin_input = 8'h3C;
      rd(5'h08, 32'h0000_0000, "IN before sync");
      rd(5'h08, 32'h0000_003C, "IN after sync");
      bus(1'b1, 5'h08, 4'hF, 32'h55, 1'b1, 1'b0, 32'd0, "write IN");
      rd(5'h08, 32'h0000_003C, "IN unchanged");

      wr(5'h0C, 32'h01, "write RISE_EN");
      wr(5'h18, 32'h01, "write MASK");
      check("irq idle", {31'd0, irq_o}, 32'd0);
      pin_input = 8'h3D;
      repeat (3) @(negedge clk);
      check("irq not before status+1", {31'd0, irq_o}, 32'd0);
      @(negedge clk);
      check("irq after rise", {31'd0, irq_o}, 32'd1);
      rd(5'h14, 32'h01, "STATUS after rise");
      wr(5'h14, 32'h01, "W1C bit0");
      check("irq after W1C", {31'd0, irq_o}, 32'd0);
      rd(5'h14, 32'h00, "STATUS cleared");

      // Clear of bit1 lands on the same edge that latches its fall event.
      wr(5'h10, 32'h02, "write FALL_EN");
      pin_input = 8'h3F;
      repeat (4) @(negedge clk);
      pin_input = 8'h3D;
      repeat (2) @(negedge clk);
      wr(5'h14, 32'h02, "W1C bit1 with fall");
      rd(5'h14, 32'h02, "STATUS set wins");
      check("irq masked", {31'd0, irq_o}, 32'd0);
      wr(5'h14, 32'h02, "W1C bit1");
      rd(5'h14, 32'h00, "STATUS bit1 cleared");

      bus(1'b1, 5'h00, 4'h3, 32'h12, 1'b1, 1'b0, 32'd0, "partial sel write");
      check("pin_output after sel err", {24'd0, pin_output}, 32'h0000_00A5);
      rd(5'h00, 32'h0000_00A5, "OUT after sel err");

      // Strobe held for four cycles: responses on cycles 1 and 3 only.
      for (int k = 0; k < 2; k++) begin
         exp_t e;
         e.err = 1'b0;
         e.chk = 1'b1;
         e.dat = 32'h0000_00A5;
         exp_q.push_back(e);
         name_q.push_back($sformatf("burst read %0d", k));
      end
      stb = 1'b1;
      cyc = 1'b1;
      we  = 1'b0;
      sel = 4'hF;
      adr = BASE;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("burst ack cycle %0d", k + 1), {31'd0, ack_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
      end
      stb = 1'b0;
      cyc = 1'b0;
      @(negedge clk);

      // Outside the window: the slave must stay silent.
      stb = 1'b1;
      cyc = 1'b1;
      adr = 32'h0000_0000;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("out-of-window silent %0d", k), {30'd0, ack_o, err_o}, 32'd0);
      end
      stb = 1'b0;
      cyc = 1'b0;
      repeat (2) @(negedge clk);
      check("scoreboard drained", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/gpio_ctrl.md
# gpio_ctrl

Parametrised Wishbone-slave GPIO controller: `WIDTH` bidirectional pins, each with a per-pin direction, a two-flop input synchroniser, and edge-detect interrupt logic with write-1-to-clear status. It sits on the SoC Wishbone bus beside the other memory-mapped peripherals and drives a single level interrupt to the CPU. It supersedes the fixed 8-in/8-out GPIO. Bus cycles take a registered single-cycle ack, and error responses are supported.

## Interface
- `BASE_ADDRESS`, default 0: byte address of register 0. Must be 32-byte aligned.
- `WIDTH`, default 8: pin count, legal range 1..32.
- `SYNC_STAGES`, default 2: input synchroniser depth, legal range 2..3.
- `clk_i` in 1: the only clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `stb_i`, `cyc_i`, `we_i` in 1: Wishbone strobe, cycle and write enable.
- `adr_i` in 32: byte address.
- `sel_i` in 4: byte selects.
- `dat_i` in 32: write data.
- `dat_o` out 32: read data.
- `ack_o`, `err_o`, `rty_o` out 1: Wishbone termination signals.
- `pin_input` in WIDTH: asynchronous pad inputs.
- `pin_output` out WIDTH: output values.
- `pin_oe` out WIDTH: output enables, 1 = drive.
- `irq_o` out 1: level interrupt.

## Operation
- Window: `adr_i[31:5] == BASE_ADDRESS[31:5]`. The word offset is `adr_i[4:2]`.
- Register map:
  - 0x00 OUT, rw: drives `pin_output`.
  - 0x04 DIR, rw: drives `pin_oe`.
  - 0x08 IN, ro: synchronised input value.
  - 0x0C RISE_EN, rw: enables rising-edge detection per pin.
  - 0x10 FALL_EN, rw: enables falling-edge detection per pin.
  - 0x14 IRQ_STATUS, W1C: latched edge events.
  - 0x18 IRQ_MASK, rw: 1 = the pin's status contributes to `irq_o`.
  - 0x1C is unmapped.
- Bits at or above WIDTH read as 0 and ignore writes.
- Only 32-bit access is supported. Any in-window request with `sel_i != 4'hF`, any access to 0x1C, and any write to IN terminate with `err_o`. No state changes on an error.
- `rty_o` is tied to 0.
- Input path: `pin_input` passes through SYNC_STAGES flops to give `sync`, plus one more flop to give `sync_d`. Rise event = `sync & ~sync_d & RISE_EN`. Fall event = `~sync & sync_d & FALL_EN`.
- IRQ_STATUS update:
  - Set: `status <= (status & ~clr) | rise | fall`, where `clr` is the W1C write data.
  - Same cycle set and clear on one bit: set wins.
  - Events are detected regardless of DIR.
- `irq_o` = `|(IRQ_STATUS & IRQ_MASK)`, registered.
- Reset values: all registers 0, so `pin_output` = 0, `pin_oe` = 0, `irq_o` = 0, `ack_o` = 0, `err_o` = 0.
- After reset the sync chain is 0. A pin that is high at reset release therefore produces a rise event if RISE_EN is later set before the chain settles. Software clears status after enabling.

## Timing
- Handshake states are IDLE and RESP:
  - IDLE → RESP when `stb_i & cyc_i & in-window & !ack_o & !err_o`. Exactly one of ack/err is registered high.
  - RESP → IDLE unconditionally. The ack/err pulse is exactly one cycle.
  - Back-to-back requests: at most one access per 2 cycles.
- Request at edge N:
  - Write data takes effect at edge N, visible on pins after edge N.
  - Ack/err is high between N and N+1.
  - Read data is captured at edge N and held on `dat_o` during RESP.
  - `dat_o` = 0 outside RESP.
- Input to IN latency: SYNC_STAGES cycles.
- Edge to IRQ_STATUS: SYNC_STAGES+1 cycles.
- IRQ_STATUS to `irq_o`: +1 cycle.
- If `cyc_i` drops during RESP, the response still completes and the write is already committed. Reset mid-cycle forces IDLE and clears all state immediately.

## Structure
- Package `gpio_ctrl_pkg` holds the register offset constants (`GPIO_OUT` … `GPIO_IRQ_MASK`) and `GPIO_MAX_WIDTH = 32`.
- One sub-module, `sync_edge`: a per-vector synchroniser plus delayed copy, parametrised by WIDTH and SYNC_STAGES. It outputs `sync` and `sync_d`.

## Test plan
- Reset, then read all 7 registers → each acks after 1 cycle with 0. Reading 0x1C gives `err_o` = 1 and `ack_o` = 0.
- WIDTH=8: write OUT=0xFFFF_FFA5 and DIR=0x0F → `pin_output` = 0xA5, `pin_oe` = 0x0F, readback OUT = 0x0000_00A5.
- `pin_input` = 0x3C → IN reads 0x3C no earlier than 2 cycles later. Write IN → `err_o`, and IN is unchanged.
- RISE_EN=0x01, MASK=0x01, pin0 0→1 → IRQ_STATUS = 0x01 after 3 cycles, `irq_o` = 1 one cycle later. W1C 0x01 → status 0, `irq_o` falls.
- W1C of bit 1 on the same cycle as a pin1 falling event with FALL_EN=0x02 → status bit 1 stays 1.
- Write with `sel_i` = 4'h3 → `err_o` pulse and OUT unchanged. `cyc_i` held with `stb_i` high for 4 cycles → ack pulses on cycles 1 and 3 only.
